// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary (thermometer) frame transmitter.
package unary_pkg;

   typedef enum logic {IDLE, SEND} tx_state_t;

   localparam int DEFAULT_FRAME = 3;

   // Clamp a requested ones-count to the number of data bits in a frame.
   function automatic int unsigned sat_count(input int unsigned count, input int unsigned frame);
      return (count > frame) ? frame : count;
   endfunction

endpackage

// File: rtl/unary_frame_tx.sv
// Serialises a binary count into an LSB-first thermometer frame over valid/ready.
// Define UNARY_FRAME_TX_PARITY_EN to append an odd-parity bit after the data bits.
module unary_frame_tx
   import unary_pkg::*;
#(
   parameter int FRAME = DEFAULT_FRAME,
   parameter int CW    = $clog2(FRAME + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [CW-1:0] count_i,
   input  logic          valid_i,
   output logic          ready_o,
   output logic          dout_o,
   output logic          dvalid_o,
   input  logic          dready_i,
   output logic          last_o
);

`ifdef UNARY_FRAME_TX_PARITY_EN
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME);
`else
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
`endif

   tx_state_t     state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      ready_o  = (state_q == IDLE);
      dvalid_o = (state_q == SEND);
      last_o   = dvalid_o && (idx_q == LAST_IDX);
      dout_o   = dvalid_o && (idx_q < cnt_q);
`ifdef UNARY_FRAME_TX_PARITY_EN
      // Data ones equal cnt, so inverting its LSB makes the frame total odd.
      if (dvalid_o && (idx_q == CW'(FRAME))) begin
         dout_o = ~cnt_q[0];
      end
`endif
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               cnt_d   = CW'(sat_count(32'(count_i), FRAME));
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (dready_i) begin
               if (last_o) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_unary_frame_tx.sv
// Directed scoreboard bench for unary_frame_tx (FRAME=3 and FRAME=5 instances).
module tb_unary_frame_tx;
   import unary_pkg::*;

`ifdef UNARY_FRAME_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk, rst_n, valid_a, valid_b, dready;
   logic [2:0] count_v;
   logic       ready_a, dout_a, dvalid_a, last_a;
   logic       ready_b, dout_b, dvalid_b, last_b;
   logic       sel;
   logic       ready_m, dout_m, dvalid_m, last_m;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];

   unary_frame_tx #(.FRAME(3)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .count_i(count_v[1:0]), .valid_i(valid_a),
      .ready_o(ready_a), .dout_o(dout_a), .dvalid_o(dvalid_a),
      .dready_i(dready), .last_o(last_a)
   );

   unary_frame_tx #(.FRAME(5)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .count_i(count_v), .valid_i(valid_b),
      .ready_o(ready_b), .dout_o(dout_b), .dvalid_o(dvalid_b),
      .dready_i(dready), .last_o(last_b)
   );

   assign ready_m  = sel ? ready_b  : ready_a;
   assign dout_m   = sel ? dout_b   : dout_a;
   assign dvalid_m = sel ? dvalid_b : dvalid_a;
   assign last_m   = sel ? last_b   : last_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: thermometer of min(count, frame) ones, then optional odd parity.
   task automatic push_frame(input int count, input int frame);
      int s;
      logic b;
      s = (count > frame) ? frame : count;
      for (int i = 0; i < frame + PAR; i++) begin
         if (i < frame) b = (i < s);
         else           b = ~s[0];
         exp_q.push_back({(i == frame + PAR - 1) ? 1'b1 : 1'b0, b});
      end
   endtask

   task automatic run_frame(input int count, input int frame, input int stall_at, input int stall_len);
      int done, cyc, stalled, flen;
      logic [1:0] e;
      done = 0; cyc = 0; stalled = 0; flen = frame + PAR;
      @(negedge clk);
      check("ready_idle", 32'(ready_m), 32'd1);
      check("dvalid_idle", 32'(dvalid_m), 32'd0);
      count_v = 3'(count);
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      push_frame(count, frame);
      @(posedge clk); #1;
      valid_a = 1'b0; valid_b = 1'b0;
      while (done < flen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         check("dvalid_busy", 32'(dvalid_m), 32'd1);
         check("ready_busy", 32'(ready_m), 32'd0);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            $display("frame cnt=%0d bit=%0d dout=%0b last=%0b dready=%0b", count, done, dout_m, last_m,
                     !(done == stall_at && stalled < stall_len));
            check("dout", 32'(dout_m), 32'(e[0]));
            check("last", 32'(last_m), 32'(e[1]));
         end
         if (done == stall_at && stalled < stall_len) begin
            dready = 1'b0;
            stalled++;
         end else begin
            dready = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            done++;
         end
      end
      if (done < flen) check("timeout", 32'(done), 32'(flen));
      @(negedge clk);
      check("ready_after", 32'(ready_m), 32'd1);
      check("dvalid_after", 32'(dvalid_m), 32'd0);
      dready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; dready = 1'b1;
      count_v = '0; sel = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_dvalid", 32'(dvalid_a), 32'd0);
      check("rst_dout", 32'(dout_a), 32'd0);
      check("rst_last", 32'(last_a), 32'd0);
      check("rst_cnt", 32'(dut_a.cnt_q), 32'd0);
      rst_n = 1'b1;

      // FRAME=3 directed frames
      run_frame(2, 3, -1, 0);
      run_frame(0, 3, -1, 0);
      run_frame(1, 3, 1, 4);
      run_frame(3, 3, 0, 2);

      // FRAME=5 saturation: count 7 clamps to 5
      sel = 1'b1;
      run_frame(7, 5, -1, 0);
      check("sat_cnt", 32'(dut_b.cnt_q), 32'd5);
      run_frame(2, 5, 2, 1);
      sel = 1'b0;

      // Asynchronous reset during the second bit of a frame
      @(negedge clk);
      count_v = 3'd1; valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
      @(negedge clk);
      check("rstmid_bit0", 32'(dout_a), 32'd1);
      @(negedge clk);
      check("rstmid_bit1", 32'(dout_a), 32'd0);
      check("rstmid_dv_pre", 32'(dvalid_a), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset mid-frame: dvalid=%0b ready=%0b", dvalid_a, ready_a);
      check("rstmid_dvalid", 32'(dvalid_a), 32'd0);
      check("rstmid_ready", 32'(ready_a), 32'd1);
      check("rstmid_last", 32'(last_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(3, 3, -1, 0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
